// File: rtl/rs_param.sv
// Reservation station: holds dispatched instructions until their operands
// arrive on the result broadcast channels, then issues the oldest ready entry
// to the ALU over a valid/ready handshake.
module rs_param #(
   parameter int DEPTH = 16,
   parameter int IDX_W = 4,
   parameter int ROB_W = 4,
   parameter int XLEN  = 32,
   parameter int INS_W = 6,
   parameter int NCDB  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  flush,
   input  logic                  in_valid,
   input  logic [INS_W-1:0]      in_insty,
   input  logic                  in_rs1_ready,
   input  logic                  in_rs2_ready,
   input  logic [XLEN-1:0]       in_reg1,
   input  logic [XLEN-1:0]       in_reg2,
   input  logic [XLEN-1:0]       in_imm,
   input  logic                  in_use_imm,
   input  logic [ROB_W-1:0]      in_rob_idx,
   output logic                  full,
   output logic [IDX_W:0]        count,
   input  logic [NCDB-1:0]       cdb_valid,
   input  logic [NCDB*ROB_W-1:0] cdb_idx,
   input  logic [NCDB*XLEN-1:0]  cdb_val,
   output logic                  iss_valid,
   input  logic                  iss_ready,
   output logic [INS_W-1:0]      iss_insty,
   output logic [XLEN-1:0]       iss_val1,
   output logic [XLEN-1:0]       iss_val2,
   output logic [ROB_W-1:0]      iss_rob_idx
);

   // {hit, value} for a tag against all broadcast channels; lowest channel wins
   function automatic logic [XLEN:0] cdb_match(
      input logic [ROB_W-1:0]      tag,
      input logic [NCDB-1:0]       v,
      input logic [NCDB*ROB_W-1:0] idx,
      input logic [NCDB*XLEN-1:0]  val
   );
      logic [XLEN:0] res;
      res = '0;
      for (int c = NCDB - 1; c >= 0; c--) begin
         if (v[c] && (idx[c*ROB_W +: ROB_W] == tag)) res = {1'b1, val[c*XLEN +: XLEN]};
      end
      return res;
   endfunction

   logic [DEPTH-1:0] r_valid, r_rdy1, r_rdy2;
   logic [INS_W-1:0] r_insty [DEPTH];
   logic [XLEN-1:0]  r_val1  [DEPTH];
   logic [XLEN-1:0]  r_val2  [DEPTH];
   logic [ROB_W-1:0] r_tag1  [DEPTH];
   logic [ROB_W-1:0] r_tag2  [DEPTH];
   logic [ROB_W-1:0] r_rob   [DEPTH];
   // r_older[j][i] set means entry j is older than entry i
   logic [DEPTH-1:0] r_older [DEPTH];
   logic [IDX_W:0]   r_count;

   logic             r_iss_valid;
   logic [INS_W-1:0] r_iss_insty;
   logic [XLEN-1:0]  r_iss_val1, r_iss_val2;
   logic [ROB_W-1:0] r_iss_rob;

   logic [XLEN:0]    w_m1 [DEPTH];
   logic [XLEN:0]    w_m2 [DEPTH];
   logic [XLEN-1:0]  w_op1 [DEPTH];
   logic [XLEN-1:0]  w_op2 [DEPTH];
   logic [DEPTH-1:0] w_ok1, w_ok2, w_cand, w_blk;
   logic             w_any, w_issue, w_alloc, w_full;
   logic [IDX_W-1:0] w_sel_idx, w_free_idx;
   logic [XLEN:0]    w_a1, w_a2;
   logic             w_a_rdy1, w_a_rdy2;
   logic [XLEN-1:0]  w_a_val1, w_a_val2;

   // Operand view of every entry including this cycle's broadcast bypass
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_m1[i]  = cdb_match(r_tag1[i], cdb_valid, cdb_idx, cdb_val);
         w_m2[i]  = cdb_match(r_tag2[i], cdb_valid, cdb_idx, cdb_val);
         w_ok1[i] = r_rdy1[i] | w_m1[i][XLEN];
         w_ok2[i] = r_rdy2[i] | w_m2[i][XLEN];
         w_op1[i] = r_rdy1[i] ? r_val1[i] : w_m1[i][XLEN-1:0];
         w_op2[i] = r_rdy2[i] ? r_val2[i] : w_m2[i][XLEN-1:0];
      end
   end

   assign w_cand = r_valid & w_ok1 & w_ok2;

   // Oldest candidate: the one with no older candidate in the age matrix
   always_comb begin
      w_any     = 1'b0;
      w_sel_idx = '0;
      w_blk     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         for (int j = 0; j < DEPTH; j++) begin
            if (w_cand[j] && r_older[j][i]) w_blk[i] = 1'b1;
         end
      end
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (w_cand[i] && !w_blk[i]) begin
            w_any     = 1'b1;
            w_sel_idx = IDX_W'(i);
         end
      end
   end

   // Lowest-index free slot for allocation
   always_comb begin
      w_free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!r_valid[i]) w_free_idx = IDX_W'(i);
      end
   end

   // Incoming operands, with same-cycle broadcast capture and immediate select
   always_comb begin
      w_a1     = cdb_match(in_reg1[ROB_W-1:0], cdb_valid, cdb_idx, cdb_val);
      w_a2     = cdb_match(in_reg2[ROB_W-1:0], cdb_valid, cdb_idx, cdb_val);
      w_a_rdy1 = in_rs1_ready | w_a1[XLEN];
      w_a_val1 = in_rs1_ready ? in_reg1 : w_a1[XLEN-1:0];
      w_a_rdy2 = in_use_imm | in_rs2_ready | w_a2[XLEN];
      if (in_use_imm)        w_a_val2 = in_imm;
      else if (in_rs2_ready) w_a_val2 = in_reg2;
      else                   w_a_val2 = w_a2[XLEN-1:0];
   end

   // Full comes from the registered count so a same-cycle issue never admits one more
   assign w_full  = (r_count == (IDX_W+1)'(DEPTH));
   assign w_alloc = in_valid && !w_full;
   assign w_issue = w_any && (!r_iss_valid || iss_ready);

   // Entry storage, age matrix, occupancy and issue register
   always_ff @(posedge clk or posedge rst) begin
      if (rst || flush) begin
         r_valid     <= '0;
         r_rdy1      <= '0;
         r_rdy2      <= '0;
         r_count     <= '0;
         r_iss_valid <= 1'b0;
         r_iss_insty <= '0;
         r_iss_val1  <= '0;
         r_iss_val2  <= '0;
         r_iss_rob   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_insty[i] <= '0;
            r_val1[i]  <= '0;
            r_val2[i]  <= '0;
            r_tag1[i]  <= '0;
            r_tag2[i]  <= '0;
            r_rob[i]   <= '0;
            r_older[i] <= '0;
         end
      end else if (rdy) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_rdy1[i] <= w_ok1[i];
            r_rdy2[i] <= w_ok2[i];
            r_val1[i] <= w_op1[i];
            r_val2[i] <= w_op2[i];
            for (int j = 0; j < DEPTH; j++) begin
               if (w_issue && (IDX_W'(i) == w_sel_idx || IDX_W'(j) == w_sel_idx))
                  r_older[i][j] <= 1'b0;
               else if (w_alloc && IDX_W'(j) == w_free_idx)
                  r_older[i][j] <= r_valid[i];
            end
         end
         if (w_alloc) begin
            r_valid[w_free_idx] <= 1'b1;
            r_insty[w_free_idx] <= in_insty;
            r_rdy1[w_free_idx]  <= w_a_rdy1;
            r_rdy2[w_free_idx]  <= w_a_rdy2;
            r_val1[w_free_idx]  <= w_a_val1;
            r_val2[w_free_idx]  <= w_a_val2;
            r_tag1[w_free_idx]  <= in_reg1[ROB_W-1:0];
            r_tag2[w_free_idx]  <= in_reg2[ROB_W-1:0];
            r_rob[w_free_idx]   <= in_rob_idx;
         end
         if (w_issue) begin
            r_valid[w_sel_idx] <= 1'b0;
            r_iss_valid        <= 1'b1;
            r_iss_insty        <= r_insty[w_sel_idx];
            r_iss_val1         <= w_op1[w_sel_idx];
            r_iss_val2         <= w_op2[w_sel_idx];
            r_iss_rob          <= r_rob[w_sel_idx];
         end else if (iss_ready) begin
            r_iss_valid <= 1'b0;
         end
         r_count <= r_count + (IDX_W+1)'(w_alloc) - (IDX_W+1)'(w_issue);
      end
   end

   assign full        = w_full;
   assign count       = r_count;
   assign iss_valid   = r_iss_valid;
   assign iss_insty   = r_iss_insty;
   assign iss_val1    = r_iss_val1;
   assign iss_val2    = r_iss_val2;
   assign iss_rob_idx = r_iss_rob;

endmodule
